// File: rtl/gpioemu_host_pkg.sv
// gpioemu_host_pkg: register map, status bit positions, FSM state encoding
// and small decode helpers shared by the gpioemu host sequencer.
// Optional build macro: GPIOEMU_HOST_CHECK_EN adds the CHK state.
package gpioemu_host_pkg;

    // Peripheral register map on the strobe bus
    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    // Status register layout: only the done bit is used for completion
    localparam int ST_DONE_BIT  = 1;
    localparam int ST_VALID_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WR_A1 = 4'd1,
        ST_WR_A2 = 4'd2,
        ST_WR_GO = 4'd3,
        ST_GAP   = 4'd4,
        ST_RD_ST = 4'd5,
        ST_RD_W  = 4'd6,
        ST_RD_L  = 4'd7,
        ST_RESP  = 4'd8
`ifdef GPIOEMU_HOST_CHECK_EN
        ,
        ST_CHK   = 4'd9
`endif
    } state_e;

    // True for the access states that use the read strobe
    function automatic logic is_read_state(input state_e s);
        logic r;
        case (s)
            ST_RD_ST, ST_RD_W, ST_RD_L: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpioemu_host_refmul.sv
// gpioemu_host_refmul: 24x24 sequential shift-add multiplier used to
// cross-check the peripheral's product. One partial product per cycle,
// 24 cycles from start to done; done stays high until the next start.
module gpioemu_host_refmul (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start_i,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    output logic        done_o,
    output logic [31:0] prod_o
);

    logic [47:0] acc_q;
    logic [47:0] mcand_q;
    logic [23:0] mplier_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    // Shift-add iteration: add the shifted multiplicand when the current multiplier bit is set
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_q    <= 48'h0;
            mcand_q  <= 48'h0;
            mplier_q <= 24'h0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= 48'h0;
            mcand_q  <= {24'h0, a_i};
            mplier_q <= b_i;
            cnt_q    <= 5'd24;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end else begin
                acc_q <= acc_q;
            end
            mcand_q  <= {mcand_q[46:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[23:1]};
            cnt_q    <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
        end else begin
            busy_q <= 1'b0;
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q[31:0];

endmodule

// File: rtl/gpioemu_host.sv
// gpioemu_host: host-side bus sequencer for the gpioemu multiply/popcount
// peripheral. Accepts one operand pair, writes A1/A2/CTRL, polls status,
// reads W and L, and returns them on a valid/ready response port.
// Each bus access is SETUP (1) + STROBE (STROBE_CYCLES) + HOLD (1) cycles.
// Optional build macro: GPIOEMU_HOST_CHECK_EN adds a local multiplier and a
// CHK state that flags a product mismatch on rsp_mismatch.
module gpioemu_host
    import gpioemu_host_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int POLL_GAP      = 2,
    parameter int POLL_MAX      = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_timeout,
    output logic        rsp_mismatch,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    // Phase counter values inside an access: 0 = SETUP, 1..LAST = STROBE, HOLD after
    localparam logic [15:0] PH_LAST_STB = 16'(STROBE_CYCLES);
    localparam logic [15:0] PH_HOLD     = 16'(STROBE_CYCLES + 1);
    localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LAST   = 16'(POLL_MAX - 1);
    localparam logic [15:0] POLL_SAT    = 16'(POLL_MAX);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] poll_q;
    logic [23:0] a1_q;
    logic [23:0] a2_q;
    logic        st_done_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_w_q;
    logic [23:0] rsp_l_q;
    logic        rsp_timeout_q;
    logic [15:0] saddress_q;
    logic        srd_q;
    logic        swr_q;
    logic [31:0] bus_wdata_q;

`ifdef GPIOEMU_HOST_CHECK_EN
    logic        mul_start_q;
    logic        mul_done_s;
    logic [31:0] mul_prod_s;
    logic        rsp_mismatch_q;

    gpioemu_host_refmul u_refmul (
        .clk     (clk),
        .n_reset (n_reset),
        .start_i (mul_start_q),
        .a_i     (a1_q),
        .b_i     (a2_q),
        .done_o  (mul_done_s),
        .prod_o  (mul_prod_s)
    );
`endif

    // Sequencer FSM: drives the strobe bus phase by phase and builds the response
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'h0;
            poll_q        <= 16'h0;
            a1_q          <= 24'h0;
            a2_q          <= 24'h0;
            st_done_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_w_q       <= 32'h0;
            rsp_l_q       <= 24'h0;
            rsp_timeout_q <= 1'b0;
            saddress_q    <= 16'h0;
            srd_q         <= 1'b0;
            swr_q         <= 1'b0;
            bus_wdata_q   <= 32'h0;
`ifdef GPIOEMU_HOST_CHECK_EN
            mul_start_q    <= 1'b0;
            rsp_mismatch_q <= 1'b0;
`endif
        end else begin
`ifdef GPIOEMU_HOST_CHECK_EN
            mul_start_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        a1_q          <= cmd_a1;
                        a2_q          <= cmd_a2;
                        poll_q        <= 16'h0;
                        cnt_q         <= 16'h0;
                        rsp_timeout_q <= 1'b0;
                        cmd_ready_q   <= 1'b0;
                        saddress_q    <= ADDR_A1;
                        bus_wdata_q   <= {8'h0, cmd_a1};
                        state_q       <= ST_WR_A1;
`ifdef GPIOEMU_HOST_CHECK_EN
                        rsp_mismatch_q <= 1'b0;
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_WR_A1, ST_WR_A2, ST_WR_GO, ST_RD_ST, ST_RD_W, ST_RD_L: begin
                    if (cnt_q == PH_HOLD) begin
                        cnt_q <= 16'h0;
                        case (state_q)
                            ST_WR_A1: begin
                                saddress_q  <= ADDR_A2;
                                bus_wdata_q <= {8'h0, a2_q};
                                state_q     <= ST_WR_A2;
                            end
                            ST_WR_A2: begin
                                saddress_q  <= ADDR_CTRL;
                                bus_wdata_q <= 32'h0;
                                state_q     <= ST_WR_GO;
                            end
                            ST_WR_GO: begin
`ifdef GPIOEMU_HOST_CHECK_EN
                                mul_start_q <= 1'b1;
`endif
                                if (POLL_GAP == 0) begin
                                    state_q <= ST_RD_ST;
                                end else begin
                                    state_q <= ST_GAP;
                                end
                            end
                            ST_RD_ST: begin
                                // Counter stops at POLL_MAX so it can never wrap
                                if (poll_q != POLL_SAT) begin
                                    poll_q <= poll_q + 16'd1;
                                end else begin
                                    poll_q <= poll_q;
                                end
                                if (st_done_q) begin
                                    saddress_q <= ADDR_W;
                                    state_q    <= ST_RD_W;
                                end else if (poll_q >= POLL_LAST) begin
                                    rsp_timeout_q <= 1'b1;
                                    rsp_w_q       <= 32'h0;
                                    rsp_l_q       <= 24'h0;
                                    rsp_valid_q   <= 1'b1;
                                    state_q       <= ST_RESP;
`ifdef GPIOEMU_HOST_CHECK_EN
                                    rsp_mismatch_q <= 1'b0;
`endif
                                end else if (POLL_GAP == 0) begin
                                    state_q <= ST_RD_ST;
                                end else begin
                                    state_q <= ST_GAP;
                                end
                            end
                            ST_RD_W: begin
                                saddress_q <= ADDR_L;
                                state_q    <= ST_RD_L;
                            end
                            ST_RD_L: begin
`ifdef GPIOEMU_HOST_CHECK_EN
                                state_q     <= ST_CHK;
`else
                                rsp_valid_q <= 1'b1;
                                state_q     <= ST_RESP;
`endif
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == 16'h0) begin
                            // SETUP done: raise the strobe matching the access direction
                            srd_q <= is_read_state(state_q);
                            swr_q <= ~is_read_state(state_q);
                        end else if (cnt_q == PH_LAST_STB) begin
                            // Last strobe cycle: capture read data and enter HOLD
                            srd_q <= 1'b0;
                            swr_q <= 1'b0;
                            case (state_q)
                                ST_RD_ST: st_done_q <= bus_rdata[ST_DONE_BIT];
                                ST_RD_W:  rsp_w_q   <= bus_rdata;
                                ST_RD_L:  rsp_l_q   <= bus_rdata[23:0];
                                default:  st_done_q <= st_done_q;
                            endcase
                        end else begin
                            srd_q <= srd_q;
                            swr_q <= swr_q;
                        end
                    end
                end

                ST_GAP: begin
                    if (cnt_q >= GAP_LAST) begin
                        cnt_q       <= 16'h0;
                        saddress_q  <= ADDR_CTRL;
                        bus_wdata_q <= 32'h0;
                        state_q     <= ST_RD_ST;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

`ifdef GPIOEMU_HOST_CHECK_EN
                ST_CHK: begin
                    if (mul_done_s) begin
                        rsp_mismatch_q <= (mul_prod_s != rsp_w_q);
                        rsp_valid_q    <= 1'b1;
                        state_q        <= ST_RESP;
                    end else begin
                        state_q <= ST_CHK;
                    end
                end
`endif

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end

                default: begin
                    srd_q       <= 1'b0;
                    swr_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_w       = rsp_w_q;
    assign rsp_l       = rsp_l_q;
    assign rsp_timeout = rsp_timeout_q;
    assign saddress    = saddress_q;
    assign srd         = srd_q;
    assign swr         = swr_q;
    assign bus_wdata   = bus_wdata_q;
`ifdef GPIOEMU_HOST_CHECK_EN
    assign rsp_mismatch = rsp_mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_gpioemu_host.sv
// tb_gpioemu_host: directed bench for gpioemu_host with a behavioural
// gpioemu peripheral on the strobe bus and a bus access monitor.
module tb_gpioemu_host;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_a1;
    logic [23:0] cmd_a2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_timeout;
    logic        rsp_mismatch;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    gpioemu_host #(
        .STROBE_CYCLES (2),
        .POLL_GAP      (2),
        .POLL_MAX      (4)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a1       (cmd_a1),
        .cmd_a2       (cmd_a2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_w        (rsp_w),
        .rsp_l        (rsp_l),
        .rsp_timeout  (rsp_timeout),
        .rsp_mismatch (rsp_mismatch),
        .saddress     (saddress),
        .srd          (srd),
        .swr          (swr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    // Behavioural peripheral
    logic [23:0] m_a1 = 24'h0;
    logic [23:0] m_a2 = 24'h0;
    logic [31:0] m_w  = 32'h0;
    logic [23:0] m_l  = 24'h0;
    int          st_reads   = 0;
    int          done_after = 1;
    bit          never_done = 1'b0;
    bit          w_override = 1'b0;

    always @(posedge swr or posedge srd) begin
        logic [47:0] p;
        if (swr) begin
            case (saddress)
                16'h0380: m_a1 = bus_wdata[23:0];
                16'h0388: m_a2 = bus_wdata[23:0];
                16'h03A0: begin
                    p = {24'h0, m_a1} * {24'h0, m_a2};
                    m_w = w_override ? 32'h00000010 : p[31:0];
                    m_l = 24'($countones(p[31:0]));
                    st_reads = 0;
                end
                default: ;
            endcase
        end else if (saddress == 16'h03A0) begin
            st_reads = st_reads + 1;
        end
    end

    always_comb begin
        case (saddress)
            16'h0390: bus_rdata = m_w;
            16'h0398: bus_rdata = {8'h0, m_l};
            16'h03A0: bus_rdata = {30'h0, (!never_done && (st_reads >= done_after)), 1'b1};
            default:  bus_rdata = 32'h0;
        endcase
    end

    // Bus access monitor
    logic [15:0] log_addr [128];
    bit          log_wr   [128];
    logic [31:0] log_data [128];
    int          log_len  [128];
    int          log_n      = 0;
    int          both_viol  = 0;
    int          addr_viol  = 0;
    bit          prev_stb   = 1'b0;
    logic [15:0] prev_addr  = 16'h0;
    int          cur_len    = 0;

    always @(negedge clk) begin
        bit stb;
        stb = (srd === 1'b1) || (swr === 1'b1);
        if (srd === 1'b1 && swr === 1'b1) both_viol = both_viol + 1;
        if (stb && prev_stb && saddress !== prev_addr) addr_viol = addr_viol + 1;
        if (stb && !prev_stb) begin
            if (log_n < 128) begin
                log_addr[log_n] = saddress;
                log_wr[log_n]   = (swr === 1'b1);
                log_data[log_n] = bus_wdata;
                log_len[log_n]  = 0;
            end
            log_n   = log_n + 1;
            cur_len = 1;
        end else if (stb) begin
            cur_len = cur_len + 1;
        end
        if (!stb && prev_stb && log_n >= 1 && log_n <= 128) log_len[log_n-1] = cur_len;
        prev_stb  = stb;
        prev_addr = saddress;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [23:0] a1, input logic [23:0] a2);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("cmd_ready_before_send", {31'h0, cmd_ready}, 32'h1);
        cmd_a1    = a1;
        cmd_a2    = a2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc = cyc + 1;
        end while (rsp_valid !== 1'b1 && cyc < budget);
        chk("rsp_valid_seen", {31'h0, rsp_valid}, 32'h1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_ready", {31'h0, rsp_valid}, 32'h0);
        chk("cmd_ready_after_ready", {31'h0, cmd_ready}, 32'h1);
    endtask

    function automatic int count_acc(input int from, input logic [15:0] a, input bit wr);
        int c;
        c = 0;
        for (int i = from; i < log_n && i < 128; i++) begin
            if (log_addr[i] == a && log_wr[i] == wr) c = c + 1;
        end
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int b;
        int seen;
        bit found;

        n_reset   = 1'b0;
        cmd_valid = 1'b0;
        cmd_a1    = 24'h0;
        cmd_a2    = 24'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready",    {31'h0, cmd_ready},    32'h1);
        chk("rst_rsp_valid",    {31'h0, rsp_valid},    32'h0);
        chk("rst_rsp_w",        rsp_w,                 32'h0);
        chk("rst_rsp_l",        {8'h0, rsp_l},         32'h0);
        chk("rst_rsp_timeout",  {31'h0, rsp_timeout},  32'h0);
        chk("rst_rsp_mismatch", {31'h0, rsp_mismatch}, 32'h0);
        chk("rst_saddress",     {16'h0, saddress},     32'h0);
        chk("rst_srd",          {31'h0, srd},          32'h0);
        chk("rst_swr",          {31'h0, swr},          32'h0);
        chk("rst_bus_wdata",    bus_wdata,             32'h0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // 3 * 5: access order, strobe widths, latency, then a 10-cycle stall
        done_after = 1;
        b = log_n;
        send_cmd(24'd3, 24'd5);
        wait_rsp(200, cyc);
`ifdef GPIOEMU_HOST_CHECK_EN
        chk("t1_latency_with_chk", {31'h0, (cyc > 27)}, 32'h1);
`else
        chk("t1_latency", cyc, 32'd27);
`endif
        chk("t1_rsp_w",       rsp_w,                32'h0000000F);
        chk("t1_rsp_l",       {8'h0, rsp_l},        32'd4);
        chk("t1_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        chk("t1_n_access",    log_n - b,            32'd6);
        chk("t1_a0_addr", {16'h0, log_addr[b]},   32'h0380);
        chk("t1_a0_wr",   {31'h0, log_wr[b]},     32'h1);
        chk("t1_a0_data", log_data[b],            32'h00000003);
        chk("t1_a0_len",  log_len[b],             32'd2);
        chk("t1_a1_addr", {16'h0, log_addr[b+1]}, 32'h0388);
        chk("t1_a1_wr",   {31'h0, log_wr[b+1]},   32'h1);
        chk("t1_a1_data", log_data[b+1],          32'h00000005);
        chk("t1_a1_len",  log_len[b+1],           32'd2);
        chk("t1_a2_addr", {16'h0, log_addr[b+2]}, 32'h03A0);
        chk("t1_a2_wr",   {31'h0, log_wr[b+2]},   32'h1);
        chk("t1_a2_data", log_data[b+2],          32'h00000000);
        chk("t1_a2_len",  log_len[b+2],           32'd2);
        chk("t1_a3_addr", {16'h0, log_addr[b+3]}, 32'h03A0);
        chk("t1_a3_wr",   {31'h0, log_wr[b+3]},   32'h0);
        chk("t1_a3_len",  log_len[b+3],           32'd2);
        chk("t1_a4_addr", {16'h0, log_addr[b+4]}, 32'h0390);
        chk("t1_a4_wr",   {31'h0, log_wr[b+4]},   32'h0);
        chk("t1_a5_addr", {16'h0, log_addr[b+5]}, 32'h0398);
        chk("t1_a5_wr",   {31'h0, log_wr[b+5]},   32'h0);
        chk("t1_a5_len",  log_len[b+5],           32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'h0, rsp_valid},   32'h1);
            chk("stall_rsp_w",     rsp_w,                32'h0000000F);
            chk("stall_rsp_l",     {8'h0, rsp_l},        32'd4);
            chk("stall_cmd_ready", {31'h0, cmd_ready},   32'h0);
            chk("stall_no_access", log_n - b,            32'd6);
            chk("stall_strobes",   {30'h0, srd, swr},    32'h0);
        end
        release_rsp();

        // Full-scale operands, then a command held across RESP completion
        b = log_n;
        send_cmd(24'hFFFFFF, 24'hFFFFFF);
        wait_rsp(200, cyc);
        chk("t2_rsp_w",        rsp_w,                 32'hFE000001);
        chk("t2_rsp_l",        {8'h0, rsp_l},         32'd8);
        chk("t2_rsp_timeout",  {31'h0, rsp_timeout},  32'h0);
        chk("t2_rsp_mismatch", {31'h0, rsp_mismatch}, 32'h0);
        cmd_a1    = 24'd7;
        cmd_a2    = 24'd9;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t2b_rsp_valid_done", {31'h0, rsp_valid}, 32'h0);
        chk("t2b_cmd_ready_rise", {31'h0, cmd_ready}, 32'h1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("t2b_accepted", {31'h0, cmd_ready}, 32'h0);
        wait_rsp(200, cyc);
        chk("t2b_rsp_w", rsp_w,         32'd63);
        chk("t2b_rsp_l", {8'h0, rsp_l}, 32'd6);
        release_rsp();

        // Timeout: done never set, POLL_MAX = 4
        never_done = 1'b1;
        b = log_n;
        send_cmd(24'd1, 24'd1);
        wait_rsp(300, cyc);
        chk("t3_rsp_timeout",  {31'h0, rsp_timeout},       32'h1);
        chk("t3_rsp_w",        rsp_w,                      32'h0);
        chk("t3_rsp_l",        {8'h0, rsp_l},              32'h0);
        chk("t3_rsp_mismatch", {31'h0, rsp_mismatch},      32'h0);
        chk("t3_status_reads", count_acc(b, 16'h03A0, 1'b0), 32'd4);
        chk("t3_n_access",     log_n - b,                  32'd7);
        release_rsp();
        never_done = 1'b0;

        // Done on the last allowed poll is not a timeout
        done_after = 4;
        b = log_n;
        send_cmd(24'h123456, 24'h000010);
        wait_rsp(300, cyc);
        chk("t4_rsp_timeout",  {31'h0, rsp_timeout},         32'h0);
        chk("t4_rsp_w",        rsp_w,                        32'h01234560);
        chk("t4_rsp_l",        {8'h0, rsp_l},                32'd9);
        chk("t4_status_reads", count_acc(b, 16'h03A0, 1'b0), 32'd4);
        release_rsp();
        done_after = 1;

        // Reset while the status read strobe is high
        never_done = 1'b1;
        send_cmd(24'd9, 24'd9);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (srd === 1'b1 && saddress === 16'h03A0) found = 1'b1;
        end
        chk("t5_found_rd_st", {31'h0, found}, 32'h1);
        #1 n_reset = 1'b0;
        #1;
        chk("t5_srd_async",       {31'h0, srd},       32'h0);
        chk("t5_swr_async",       {31'h0, swr},       32'h0);
        chk("t5_cmd_ready_async", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        never_done = 1'b0;
        @(negedge clk);
        chk("t5_cmd_ready_after", {31'h0, cmd_ready}, 32'h1);
        chk("t5_rsp_valid_after", {31'h0, rsp_valid}, 32'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || srd === 1'b1 || swr === 1'b1) seen = seen + 1;
        end
        chk("t5_no_response", seen, 32'd0);
        send_cmd(24'd2, 24'd2);
        wait_rsp(200, cyc);
        chk("t5_rsp_w",       rsp_w,                32'd4);
        chk("t5_rsp_l",       {8'h0, rsp_l},        32'd1);
        chk("t5_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        release_rsp();

        // Peripheral returns a wrong product for 3 * 5
        w_override = 1'b1;
        send_cmd(24'd3, 24'd5);
        wait_rsp(300, cyc);
        chk("t6_rsp_w", rsp_w,         32'h00000010);
        chk("t6_rsp_l", {8'h0, rsp_l}, 32'd4);
`ifdef GPIOEMU_HOST_CHECK_EN
        chk("t6_rsp_mismatch", {31'h0, rsp_mismatch}, 32'h1);
`else
        chk("t6_rsp_mismatch", {31'h0, rsp_mismatch}, 32'h0);
`endif
        release_rsp();
        w_override = 1'b0;

        // Whole-run bus protocol properties
        chk("both_strobes_high", both_viol, 32'd0);
        chk("addr_change_in_strobe", addr_viol, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
